hazard_stall_ctrl: RTL and testbench

//  Stall side of the pipeline hazard logic, complementing forwarding detection.
//  ID stage reads src1/src2 against in-flight destinations. Detects RAW hazards

---
 rtl/hazard_stall_ctrl_if.sv | 40 ++++
 rtl/hazard_stall_ctrl.sv | 115 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bus: ID-stage sources, EXE/MEM producer info, data-memory
// handshake and the resulting stall/freeze/monitor outputs.
interface hazard_stall_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             i_fwd_en;
   logic [4:0]       i_src1;
   logic [4:0]       i_src2;
   logic             i_two_src;
   logic [4:0]       i_dest_exe;
   logic             i_wb_en_exe;
   logic             i_mem_r_en_exe;
   logic [4:0]       i_dest_mem;
   logic             i_wb_en_mem;
   logic             i_mem_req;
   logic             i_mem_ready;
   logic             i_perf_clr;
   logic             o_hazard_stall;
   logic             o_mem_freeze;
   logic             o_mem_timeout;
   logic [CNT_W-1:0] o_stall_cnt;

   // Pipeline side: drives hazard inputs, consumes stall/freeze decisions
   modport master (
      output i_fwd_en, i_src1, i_src2, i_two_src,
             i_dest_exe, i_wb_en_exe, i_mem_r_en_exe,
             i_dest_mem, i_wb_en_mem,
             i_mem_req, i_mem_ready, i_perf_clr,
      input  o_hazard_stall, o_mem_freeze, o_mem_timeout, o_stall_cnt
   );

   // Controller side
   modport slave (
      input  i_fwd_en, i_src1, i_src2, i_two_src,
             i_dest_exe, i_wb_en_exe, i_mem_r_en_exe,
             i_dest_mem, i_wb_en_mem,
             i_mem_req, i_mem_ready, i_perf_clr,
      output o_hazard_stall, o_mem_freeze, o_mem_timeout, o_stall_cnt
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall side of the pipeline hazard logic: RAW hazards forwarding cannot cover,
// data-memory freeze with a sticky wait timeout, and a saturating stall counter.
module hazard_stall_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 16
) (
   input  logic                i_clk,
   input  logic                i_rst,
   hazard_stall_ctrl_if.slave  bus
);

   localparam int WCNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WCNT_W-1:0] r_wait_cnt;
   logic [WCNT_W-1:0] w_wait_nxt;
   logic              r_timeout;
   logic              w_timeout_nxt;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_match_exe;
   logic              w_match_mem;
   logic              w_raw_hz;
   logic              w_mem_freeze;
   logic              w_hazard_stall;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [WCNT_W-1:0] sat_inc_wait(input logic [WCNT_W-1:0] v);
      return (v >= WCNT_W'(MAX_WAIT)) ? WCNT_W'(MAX_WAIT) : v + 1'b1;
   endfunction

   // Hazard detection; register 0 is never a real producer, and a full-pipe
   // freeze overrides the bubble because nothing moves anyway
   always_comb begin
      w_match_exe = bus.i_wb_en_exe && (bus.i_dest_exe != 5'd0) &&
                    ((bus.i_src1 == bus.i_dest_exe) ||
                     (bus.i_two_src && (bus.i_src2 == bus.i_dest_exe)));
      w_match_mem = bus.i_wb_en_mem && (bus.i_dest_mem != 5'd0) &&
                    ((bus.i_src1 == bus.i_dest_mem) ||
                     (bus.i_two_src && (bus.i_src2 == bus.i_dest_mem)));
      w_raw_hz       = bus.i_fwd_en ? (w_match_exe && bus.i_mem_r_en_exe)
                                    : (w_match_exe || w_match_mem);
      w_mem_freeze   = bus.i_mem_req && !bus.i_mem_ready;
      w_hazard_stall = w_raw_hz && !w_mem_freeze;
   end

   // Memory-wait FSM next state; timeout fires on the edge that completes
   // MAX_WAIT consecutive frozen cycles
   always_comb begin
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait_cnt;
      w_timeout_nxt = r_timeout;
      case (r_state)
         RUN: begin
            if (w_mem_freeze) begin
               w_state_nxt = MEM_WAIT;
               w_wait_nxt  = WCNT_W'(1);
            end else begin
               w_wait_nxt  = '0;
            end
         end
         MEM_WAIT: begin
            if (bus.i_mem_ready || !bus.i_mem_req) begin
               w_state_nxt = RUN;
               w_wait_nxt  = '0;
            end else begin
               if (r_wait_cnt == WCNT_W'(MAX_WAIT - 1)) begin
                  w_timeout_nxt = 1'b1;
               end
               w_wait_nxt = sat_inc_wait(r_wait_cnt);
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_wait_nxt  = '0;
         end
      endcase
   end

   // FSM state, wait counter and sticky timeout registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   // Stall-cycle performance counter; clear beats a simultaneous stall
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_stall_cnt <= '0;
      end else if (bus.i_perf_clr) begin
         r_stall_cnt <= '0;
      end else if (w_hazard_stall) begin
         r_stall_cnt <= sat_inc_cnt(r_stall_cnt);
      end
   end

   assign bus.o_hazard_stall = w_hazard_stall;
   assign bus.o_mem_freeze   = w_mem_freeze;
   assign bus.o_mem_timeout  = r_timeout;
   assign bus.o_stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: table of combinational vectors plus hand-written
// multi-cycle sequences, expected values queued at drive time and checked later.
// A 4-bit stall counter is used so saturation is reachable in a few cycles.
module tb_hazard_stall_ctrl;

   localparam int MAX_WAIT = 16;
   localparam int CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic       fwd;
      logic [4:0] s1;
      logic [4:0] s2;
      logic       two;
      logic [4:0] de;
      logic       we;
      logic       ld;
      logic [4:0] dm;
      logic       wm;
      logic       req;
      logic       rdy;
      logic       clr;
      logic       ehs;
      logic       efz;
   } vec_t;

   typedef struct packed {
      logic             hs;
      logic             fz;
      logic             to;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

   hazard_stall_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   exp_t q[$];

   // reference model state (values after the most recent edge)
   int               m_state;
   int               m_wait;
   logic             m_to;
   logic [CNT_W-1:0] m_cnt;

   function automatic vec_t mk(logic fwd, logic [4:0] s1, logic [4:0] s2, logic two,
                               logic [4:0] de, logic we, logic ld,
                               logic [4:0] dm, logic wm,
                               logic req, logic rdy, logic clr,
                               logic ehs, logic efz);
      vec_t v;
      v.fwd = fwd; v.s1 = s1; v.s2 = s2; v.two = two;
      v.de = de; v.we = we; v.ld = ld; v.dm = dm; v.wm = wm;
      v.req = req; v.rdy = rdy; v.clr = clr; v.ehs = ehs; v.efz = efz;
      return v;
   endfunction

   task automatic check1(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      bus.i_fwd_en       = v.fwd;
      bus.i_src1         = v.s1;
      bus.i_src2         = v.s2;
      bus.i_two_src      = v.two;
      bus.i_dest_exe     = v.de;
      bus.i_wb_en_exe    = v.we;
      bus.i_mem_r_en_exe = v.ld;
      bus.i_dest_mem     = v.dm;
      bus.i_wb_en_mem    = v.wm;
      bus.i_mem_req      = v.req;
      bus.i_mem_ready    = v.rdy;
      bus.i_perf_clr     = v.clr;
   endtask

   task automatic model_reset();
      m_state = 0;
      m_wait  = 0;
      m_to    = 1'b0;
      m_cnt   = '0;
   endtask

   // advance the model across one rising edge with inputs v held
   task automatic model_step(vec_t v);
      logic fz;
      fz = v.req && !v.rdy;
      if (m_state == 0) begin
         if (fz) begin
            m_state = 1;
            m_wait  = 1;
         end else begin
            m_wait  = 0;
         end
      end else if (!fz) begin
         m_state = 0;
         m_wait  = 0;
      end else begin
         if (m_wait == MAX_WAIT - 1) m_to = 1'b1;
         if (m_wait < MAX_WAIT) m_wait++;
      end
      if (v.clr) m_cnt = '0;
      else if (v.ehs && (m_cnt != CNT_MAX)) m_cnt = m_cnt + 1'b1;
   endtask

   // called at a falling edge: drive, queue expectation, compare, step model
   task automatic run_vec(string nm, vec_t v);
      exp_t e;
      drive(v);
      q.push_back({v.ehs, v.efz, m_to, m_cnt});
      #1;
      e = q.pop_front();
      check1({nm, "_hs"},  32'(bus.o_hazard_stall), 32'(e.hs));
      check1({nm, "_fz"},  32'(bus.o_mem_freeze),   32'(e.fz));
      check1({nm, "_to"},  32'(bus.o_mem_timeout),  32'(e.to));
      check1({nm, "_cnt"}, 32'(bus.o_stall_cnt),    32'(e.cnt));
      model_step(v);
      @(negedge clk);
   endtask

   vec_t tbl[15];
   vec_t idle, lu5, frz_hz;

   initial begin
      // fields: fwd s1 s2 two | de we ld | dm wm | req rdy clr | exp_hs exp_fz
      tbl[0]  = mk(0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0,  0, 0);
      tbl[1]  = mk(1, 5, 0, 0,  5, 1, 1,  0, 0,  0, 0, 0,  1, 0);
      tbl[2]  = mk(1, 5, 0, 0,  5, 1, 0,  0, 0,  0, 0, 0,  0, 0);
      tbl[3]  = mk(0, 1, 7, 0,  0, 0, 0,  7, 1,  0, 0, 0,  0, 0);
      tbl[4]  = mk(0, 1, 7, 1,  0, 0, 0,  7, 1,  0, 0, 0,  1, 0);
      tbl[5]  = mk(1, 0, 0, 0,  0, 1, 1,  0, 0,  0, 0, 0,  0, 0);
      tbl[6]  = mk(0, 0, 0, 1,  0, 1, 1,  0, 1,  0, 0, 0,  0, 0);
      tbl[7]  = mk(1, 7, 0, 0,  0, 0, 0,  7, 1,  0, 0, 0,  0, 0);
      tbl[8]  = mk(0, 2, 9, 1,  9, 1, 0,  0, 0,  0, 0, 0,  1, 0);
      tbl[9]  = mk(1, 2, 4, 1,  4, 1, 1,  0, 0,  0, 0, 0,  1, 0);
      tbl[10] = mk(1, 2, 4, 0,  4, 1, 1,  0, 0,  0, 0, 0,  0, 0);
      tbl[11] = mk(0, 6, 0, 0,  6, 0, 1,  0, 0,  0, 0, 0,  0, 0);
      tbl[12] = mk(1, 5, 0, 0,  5, 1, 1,  0, 0,  1, 1, 0,  1, 0);
      tbl[13] = mk(1, 5, 0, 0,  5, 1, 1,  0, 0,  1, 0, 0,  0, 1);
      tbl[14] = mk(0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0,  0, 0);

      idle   = tbl[0];
      lu5    = tbl[1];
      frz_hz = tbl[13];

      // reset state: registered outputs zero, stall still combinational
      rst = 1'b1;
      model_reset();
      drive(lu5);
      @(negedge clk);
      check1("rst_to",  32'(bus.o_mem_timeout),  32'd0);
      check1("rst_cnt", 32'(bus.o_stall_cnt),    32'd0);
      check1("rst_hs",  32'(bus.o_hazard_stall), 32'd1);
      check1("rst_fz",  32'(bus.o_mem_freeze),   32'd0);
      drive(idle);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

      // load-use with forwarding: one bubble, then the load is forwarded from MEM
      run_vec("clrA", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      run_vec("lu_exe", lu5);
      run_vec("lu_mem", mk(1, 5, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0));
      check1("lu_cnt", 32'(bus.o_stall_cnt), 32'd1);

      // no forwarding: producer stalls consumer in EXE and again in MEM
      run_vec("nf_exe", mk(0, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0));
      run_vec("nf_mem", mk(0, 3, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0));
      run_vec("nf_gone", mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      check1("nf_cnt", 32'(bus.o_stall_cnt), 32'd3);

      // memory wait: freeze masks stall, timeout after the 16th frozen edge
      for (int i = 0; i < MAX_WAIT; i++) begin
         if (i == MAX_WAIT - 1) check1("to_before", 32'(bus.o_mem_timeout), 32'd0);
         run_vec($sformatf("wait%0d", i), frz_hz);
      end
      check1("to_after", 32'(bus.o_mem_timeout), 32'd1);
      run_vec("rdy", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
      run_vec("post_rdy", idle);
      check1("to_sticky", 32'(bus.o_mem_timeout), 32'd1);

      // counter saturation, then clear wins over a same-cycle stall
      for (int i = 0; i < 20; i++) run_vec($sformatf("sat%0d", i), lu5);
      check1("sat_cnt", 32'(bus.o_stall_cnt), 32'(CNT_MAX));
      run_vec("clr_win", mk(1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1, 1, 0));
      check1("clr_cnt", 32'(bus.o_stall_cnt), 32'd0);

      // asynchronous reset in the middle of a long memory wait
      for (int i = 0; i < 3; i++) run_vec($sformatf("pre%0d", i), lu5);
      for (int i = 0; i < 5; i++) run_vec($sformatf("mw%0d", i), frz_hz);
      #2;
      rst = 1'b1;
      #1;
      check1("arst_to",  32'(bus.o_mem_timeout), 32'd0);
      check1("arst_cnt", 32'(bus.o_stall_cnt),   32'd0);
      check1("arst_fz",  32'(bus.o_mem_freeze),  32'd1);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      // wait counter restarted: 15 frozen edges must not time out
      for (int i = 0; i < MAX_WAIT - 1; i++) run_vec($sformatf("rw%0d", i), frz_hz);
      check1("rw_to", 32'(bus.o_mem_timeout), 32'd0);
      run_vec("end_idle", idle);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
